// File: rtl/psum_writeback_pkg.sv
// Shared definitions for the partial-sum writeback block: FSM encoding and
// default geometry of the array tile being drained.
package psum_writeback_pkg;

  localparam int COL_DEF     = 4;
  localparam int PSUM_BW_DEF = 16;
  localparam int NUM_INP_DEF = 8;
  localparam int ADDR_BW_DEF = 11;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_POP  = 3'd1,
    S_RD   = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/psum_writeback_lane_alu.sv
// One lane of the writeback datapath: wrap-around add of the new row value and
// the stored partial sum, followed by optional ReLU clamp.
module psum_lane_alu
  import psum_writeback_pkg::*;
#(
  parameter int psum_bw = PSUM_BW_DEF
) (
  input  logic [psum_bw-1:0] row_i,
  input  logic [psum_bw-1:0] stored_i,
  input  logic               relu_i,
  output logic [psum_bw-1:0] result_o
);

  logic [psum_bw-1:0] sum;

  // Two's-complement add truncated to psum_bw; signedness only matters for ReLU.
  assign sum      = row_i + stored_i;
  assign result_o = (relu_i && sum[psum_bw-1]) ? '0 : sum;

endmodule

// File: rtl/psum_writeback.sv
// Drains one tile of rows from the output FIFO into psum memory, optionally
// accumulating onto the stored partial sums (read-modify-write per row).
module psum_writeback
  import psum_writeback_pkg::*;
#(
  parameter int col     = COL_DEF,
  parameter int psum_bw = PSUM_BW_DEF,
  parameter int num_inp = NUM_INP_DEF,
  parameter int addr_bw = ADDR_BW_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [addr_bw-1:0]       base_addr,
  input  logic                     acc,
  input  logic                     relu,
  input  logic                     o_valid,
  input  logic [col*psum_bw-1:0]   ofifo_out,
  output logic                     rd_ofifo,
  output logic                     mem_cen,
  output logic                     mem_wen,
  output logic [addr_bw-1:0]       mem_addr,
  output logic [col*psum_bw-1:0]   mem_din,
  input  logic [col*psum_bw-1:0]   mem_dout,
  output logic                     busy,
  output logic                     done,
  output state_t                   dbg_state
);

  localparam int W      = col * psum_bw;
  localparam int CNT_BW = (num_inp > 1) ? $clog2(num_inp) : 1;
  localparam logic [CNT_BW-1:0] CNT_LAST = CNT_BW'(num_inp - 1);

  state_t              state_q, state_d;
  logic [CNT_BW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]        row_q, row_d;
  logic [W-1:0]        stored_q, stored_d;
  logic [addr_bw-1:0]  base_q, base_d;
  logic                acc_q, acc_d;
  logic                relu_q, relu_d;
  logic [addr_bw-1:0]  row_addr;
  logic [W-1:0]        lane_res;

  assign row_addr  = base_q + addr_bw'(cnt_q);
  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

  for (genvar l = 0; l < col; l++) begin : g_lane
    psum_lane_alu #(.psum_bw(psum_bw)) u_alu (
      .row_i    (row_q[l*psum_bw +: psum_bw]),
      .stored_i (acc_q ? stored_q[l*psum_bw +: psum_bw] : '0),
      .relu_i   (relu_q),
      .result_o (lane_res[l*psum_bw +: psum_bw])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      row_q    <= '0;
      stored_q <= '0;
      base_q   <= '0;
      acc_q    <= 1'b0;
      relu_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      row_q    <= row_d;
      stored_q <= stored_d;
      base_q   <= base_d;
      acc_q    <= acc_d;
      relu_q   <= relu_d;
    end
  end

  // FIFO handshake: a row transfers in any cycle where o_valid && rd_ofifo;
  // rd_ofifo is only raised in POP while o_valid is high, so it never pops empty.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    row_d    = row_q;
    stored_d = stored_q;
    base_d   = base_q;
    acc_d    = acc_q;
    relu_d   = relu_q;
    rd_ofifo = 1'b0;
    mem_cen  = 1'b1;
    mem_wen  = 1'b1;
    mem_addr = '0;
    mem_din  = '0;
    done     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_POP;
          cnt_d   = '0;
          base_d  = base_addr;
          acc_d   = acc;
          relu_d  = relu;
        end
      end
      S_POP: begin
        if (o_valid) begin
          rd_ofifo = 1'b1;
          row_d    = ofifo_out;
          if (acc_q) begin
            mem_cen  = 1'b0;
            mem_addr = row_addr;
            state_d  = S_RD;
          end else begin
            state_d  = S_WR;
          end
        end
      end
      S_RD: begin
        stored_d = mem_dout;
        state_d  = S_WR;
      end
      S_WR: begin
        mem_cen  = 1'b0;
        mem_wen  = 1'b0;
        mem_addr = row_addr;
        mem_din  = lane_res;
        cnt_d    = cnt_q + 1'b1;
        state_d  = (cnt_q == CNT_LAST) ? S_DONE : S_POP;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_psum_writeback.sv
// Directed bench for psum_writeback with a FIFO model and a psum memory model.
module tb_psum_writeback;
  import psum_writeback_pkg::*;

  localparam int COL = 4;
  localparam int PBW = 16;
  localparam int NROW = 8;
  localparam int ABW = 11;
  localparam int W = COL * PBW;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset, start, acc, relu, o_valid;
  logic [ABW-1:0] base_addr, mem_addr;
  logic [W-1:0]   ofifo_out, mem_din, mem_dout;
  logic           rd_ofifo, mem_cen, mem_wen, busy, done;
  state_t         dbg_state;

  psum_writeback #(.col(COL), .psum_bw(PBW), .num_inp(NROW), .addr_bw(ABW)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .acc(acc),
    .relu(relu), .o_valid(o_valid), .ofifo_out(ofifo_out), .rd_ofifo(rd_ofifo),
    .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // FIFO and memory models
  logic [W-1:0]   fifo_mem [0:15];
  int             fifo_wr, fifo_rd;
  logic [W-1:0]   mem [0:2047];
  logic [W-1:0]   dout_q;
  logic           tb_clr, pre_we;
  logic [ABW-1:0] pre_addr;
  logic [W-1:0]   pre_data;
  int             wr_cnt, pop_cnt, overlap_cnt;
  logic [ABW-1:0] wr_log [0:15];

  assign o_valid   = (fifo_rd != fifo_wr);
  assign ofifo_out = fifo_mem[fifo_rd[3:0]];
  assign mem_dout  = dout_q;

  always @(posedge clk) begin
    if (rd_ofifo === 1'b1 && mem_cen === 1'b0 && mem_wen === 1'b0) overlap_cnt <= overlap_cnt + 1;
    if (tb_clr) begin
      fifo_rd <= fifo_wr;
      wr_cnt  <= 0;
      pop_cnt <= 0;
    end else begin
      if (rd_ofifo === 1'b1 && o_valid) begin
        fifo_rd <= fifo_rd + 1;
        pop_cnt <= pop_cnt + 1;
      end
      if (mem_cen === 1'b0 && mem_wen === 1'b0) begin
        if (wr_cnt < 16) wr_log[wr_cnt[3:0]] <= mem_addr;
        wr_cnt <= wr_cnt + 1;
      end
    end
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (mem_cen === 1'b0 && mem_wen === 1'b0) mem[mem_addr] <= mem_din;
    if (mem_cen === 1'b0 && mem_wen === 1'b1) dout_q <= mem[mem_addr];
  end

  // scoreboard counters
  int checks = 0;
  int errors = 0;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    @(negedge clk);
    tb_clr = 1'b1;
    tick();
    tb_clr = 1'b0;
  endtask

  task automatic preload(input logic [ABW-1:0] a, input logic [W-1:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    tick();
    pre_we = 1'b0;
  endtask

  task automatic push_row(input logic [W-1:0] d);
    fifo_mem[fifo_wr[3:0]] = d;
    fifo_wr = fifo_wr + 1;
  endtask

  task automatic start_tile(input logic [ABW-1:0] a, input logic ac, input logic rl);
    @(negedge clk);
    start = 1'b1; base_addr = a; acc = ac; relu = rl;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
  endtask

  task automatic wait_writes(input int n, output bit ok);
    int guard = 0;
    while (wr_cnt < n && guard < 200) begin
      tick();
      guard++;
    end
    ok = (wr_cnt >= n);
  endtask

  // scenarios
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++; if (rd_ofifo !== 1'b0) begin errors++; $display("FAIL reset_rd_ofifo: got %b expected 0", rd_ofifo); end
    checks++; if (mem_cen !== 1'b1) begin errors++; $display("FAIL reset_mem_cen: got %b expected 1", mem_cen); end
    checks++; if (mem_wen !== 1'b1) begin errors++; $display("FAIL reset_mem_wen: got %b expected 1", mem_wen); end
    checks++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
    checks++; if (mem_din !== '0) begin errors++; $display("FAIL reset_mem_din: got %h expected 0", mem_din); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (dbg_state !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, S_IDLE); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_overwrite();
    int cyc;
    clear_log();
    for (int k = 0; k < NROW; k++) push_row({4{16'(k + 1)}});
    start_tile(11'd0, 1'b0, 1'b0);
    checks++; if (busy !== 1'b1 || dbg_state !== S_POP) begin errors++; $display("FAIL ow_busy: got busy=%b state=%0d expected busy=1 state=%0d", busy, dbg_state, S_POP); end
    wait_done(cyc);
    checks++; if (cyc != 16) begin errors++; $display("FAIL ow_done_latency: got %0d expected 16", cyc); end
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL ow_after_done: got done=%b busy=%b expected 0 0", done, busy); end
    for (int k = 0; k < NROW; k++) begin
      checks++;
      if (mem[k] !== {4{16'(k + 1)}}) begin errors++; $display("FAIL ow_mem[%0d]: got %h expected %h", k, mem[k], {4{16'(k + 1)}}); end
    end
    checks++; if (wr_cnt != 8 || pop_cnt != 8) begin errors++; $display("FAIL ow_counts: got writes=%0d pops=%0d expected 8 8", wr_cnt, pop_cnt); end
  endtask

  task automatic test_acc_relu();
    int cyc;
    logic [W-1:0] row0, exp0;
    row0 = {16'h0003, 16'hFFF9, 16'h0003, 16'hFFF9};
    for (int r = 0; r < 2; r++) begin
      exp0 = (r == 0) ? {16'h0008, 16'h0000, 16'h0008, 16'h0000}
                      : {16'h0008, 16'hFFFE, 16'h0008, 16'hFFFE};
      clear_log();
      for (int k = 0; k < NROW; k++) preload(11'(100 + k), {4{16'h0005}});
      push_row(row0);
      for (int k = 1; k < NROW; k++) push_row({4{16'(k)}});
      start_tile(11'd100, 1'b1, (r == 0));
      wait_done(cyc);
      checks++; if (cyc != 24) begin errors++; $display("FAIL acc_latency r%0d: got %0d expected 24", r, cyc); end
      if (r == 0) begin
        start = 1'b1; base_addr = 11'd950;
        tick();
        start = 1'b0;
        checks++; if (dbg_state !== S_IDLE || busy !== 1'b0) begin errors++; $display("FAIL start_in_done: got state=%0d busy=%b expected %0d 0", dbg_state, busy, S_IDLE); end
        repeat (2) tick();
      end
      checks++; if (mem[100] !== exp0) begin errors++; $display("FAIL acc_row0 r%0d: got %h expected %h", r, mem[100], exp0); end
      for (int k = 1; k < NROW; k++) begin
        checks++;
        if (mem[100 + k] !== {4{16'(k + 5)}}) begin errors++; $display("FAIL acc_row%0d r%0d: got %h expected %h", k, r, mem[100 + k], {4{16'(k + 5)}}); end
      end
      checks++; if (wr_cnt != 8) begin errors++; $display("FAIL acc_writes r%0d: got %0d expected 8", r, wr_cnt); end
    end
  endtask

  task automatic test_wrap();
    int cyc;
    logic [W-1:0] exp_v;
    exp_v = {16'h0002, 16'h0000, 16'h7FFF, 16'h8000};
    clear_log();
    for (int k = 0; k < NROW; k++) preload(11'(200 + k), {16'h0001, 16'hFFFF, 16'h8000, 16'h7FFF});
    for (int k = 0; k < NROW; k++) push_row({16'h0001, 16'h0001, 16'hFFFF, 16'h0001});
    start_tile(11'd200, 1'b1, 1'b0);
    wait_done(cyc);
    for (int k = 0; k < NROW; k++) begin
      checks++;
      if (mem[200 + k] !== exp_v) begin errors++; $display("FAIL wrap_mem[%0d]: got %h expected %h", 200 + k, mem[200 + k], exp_v); end
    end
  endtask

  task automatic test_addr_wrap();
    int cyc;
    logic [ABW-1:0] exp_a [0:7];
    exp_a = '{11'd2046, 11'd2047, 11'd0, 11'd1, 11'd2, 11'd3, 11'd4, 11'd5};
    clear_log();
    for (int k = 0; k < NROW; k++) push_row({4{16'(k + 16'h10)}});
    start_tile(11'd2046, 1'b0, 1'b0);
    wait_done(cyc);
    checks++; if (cyc != 16) begin errors++; $display("FAIL awrap_latency: got %0d expected 16", cyc); end
    for (int k = 0; k < NROW; k++) begin
      checks++;
      if (wr_log[k] !== exp_a[k]) begin errors++; $display("FAIL awrap_addr[%0d]: got %0d expected %0d", k, wr_log[k], exp_a[k]); end
    end
    checks++; if (mem[2047] !== {4{16'h0011}}) begin errors++; $display("FAIL awrap_mem2047: got %h expected %h", mem[2047], {4{16'h0011}}); end
    checks++; if (mem[0] !== {4{16'h0012}}) begin errors++; $display("FAIL awrap_mem0: got %h expected %h", mem[0], {4{16'h0012}}); end
  endtask

  task automatic test_stall();
    int cyc;
    bit ok;
    clear_log();
    for (int k = 0; k < NROW; k++) preload(11'(300 + k), {4{16'h0100}});
    for (int k = 0; k < 3; k++) push_row({4{16'(k + 1)}});
    start_tile(11'd300, 1'b1, 1'b0);
    wait_writes(3, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stall_reach3: got %0d writes expected 3", wr_cnt); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rd_ofifo !== 1'b0 || mem_cen !== 1'b1 || dbg_state !== S_POP) begin
        errors++; $display("FAIL stall_idle c%0d: got rd=%b cen=%b state=%0d expected 0 1 %0d", i, rd_ofifo, mem_cen, dbg_state, S_POP);
      end
      start = (i == 1); base_addr = 11'd900;
      tick();
    end
    start = 1'b0;
    for (int k = 3; k < NROW; k++) push_row({4{16'(k + 1)}});
    wait_done(cyc);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL stall_done: got %b expected 1", done); end
    checks++; if (wr_cnt != 8) begin errors++; $display("FAIL stall_writes: got %0d expected 8", wr_cnt); end
    checks++; if (wr_log[7] !== 11'd307) begin errors++; $display("FAIL stall_last_addr: got %0d expected 307", wr_log[7]); end
    for (int k = 0; k < NROW; k++) begin
      checks++;
      if (mem[300 + k] !== {4{16'(k + 16'h0101)}}) begin errors++; $display("FAIL stall_mem[%0d]: got %h expected %h", 300 + k, mem[300 + k], {4{16'(k + 16'h0101)}}); end
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit ok;
    clear_log();
    for (int k = 4; k < NROW; k++) preload(11'(400 + k), 64'hDEAD_BEEF_0000_0000 | 64'(k));
    for (int k = 0; k < NROW; k++) push_row({4{16'(k + 16'h40)}});
    start_tile(11'd400, 1'b0, 1'b0);
    wait_writes(4, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rmid_reach4: got %0d writes expected 4", wr_cnt); end
    reset = 1'b1;
    tick();
    checks++;
    if (rd_ofifo !== 1'b0 || mem_cen !== 1'b1 || mem_wen !== 1'b1 || mem_addr !== '0 ||
        mem_din !== '0 || busy !== 1'b0 || done !== 1'b0 || dbg_state !== S_IDLE) begin
      errors++; $display("FAIL rmid_outputs: got rd=%b cen=%b wen=%b addr=%h din=%h busy=%b done=%b state=%0d expected reset values",
                         rd_ofifo, mem_cen, mem_wen, mem_addr, mem_din, busy, done, dbg_state);
    end
    reset = 1'b0;
    repeat (6) tick();
    checks++; if (wr_cnt != 4) begin errors++; $display("FAIL rmid_writes: got %0d expected 4", wr_cnt); end
    checks++; if (mem[403] !== {4{16'h0043}}) begin errors++; $display("FAIL rmid_row3: got %h expected %h", mem[403], {4{16'h0043}}); end
    for (int k = 4; k < NROW; k++) begin
      checks++;
      if (mem[400 + k] !== (64'hDEAD_BEEF_0000_0000 | 64'(k))) begin errors++; $display("FAIL rmid_untouched[%0d]: got %h expected %h", 400 + k, mem[400 + k], 64'hDEAD_BEEF_0000_0000 | 64'(k)); end
    end
    clear_log();
    for (int k = 0; k < NROW; k++) push_row({4{16'(k + 16'h50)}});
    start_tile(11'd500, 1'b0, 1'b0);
    wait_done(cyc);
    checks++; if (cyc != 16) begin errors++; $display("FAIL rmid_restart_latency: got %0d expected 16", cyc); end
    for (int k = 0; k < NROW; k++) begin
      checks++;
      if (mem[500 + k] !== {4{16'(k + 16'h50)}}) begin errors++; $display("FAIL rmid_restart_mem[%0d]: got %h expected %h", 500 + k, mem[500 + k], {4{16'(k + 16'h50)}}); end
    end
  endtask

  task automatic test_no_overlap();
    checks++;
    if (overlap_cnt != 0) begin errors++; $display("FAIL pop_write_overlap: got %0d cycles expected 0", overlap_cnt); end
  endtask

  initial begin
    tb_clr = 1'b0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    start = 1'b0; base_addr = '0; acc = 1'b0; relu = 1'b0;
    reset = 1'b1;
    test_reset();
    test_overwrite();
    test_acc_relu();
    test_wrap();
    test_addr_wrap();
    test_stall();
    test_reset_mid();
    test_no_overlap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
